crc_unfold_engine: RTL
======================

# crc_unfold_engine

Parametrised, multi-cycle CRC engine computing the remainder of a fixed-length message divided by a generator polynomial, processing J message bits per clock (unfolded LFSR). It is the generalised successor to our fixed 6-bit / CRC-5 / unfold-by-3 block. It adds configurable CRC width, polynomial, init value, message length and unfold factor, a start/busy/done handshake, and correct handling of a partial final beat. It sits between a message source and any checker or appender that consumes `data_out`.

## Interface
- `CRC_W`, default 5: CRC width in bits, range 2..32.
- `POLY`, default 5'b00101: generator polynomial without the implicit x^CRC_W term. The default is x^5+x^2+1.
- `INIT`, default 0: CRC register value loaded at start.
- `MSG_W`, default 6: message width in bits, ≥1.
- `J`, default 3: bits processed per cycle, range 1..MSG_W.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a computation. Sampled only in IDLE.
- `data_in` input MSG_W: message, MSB first. Sampled on the accepting edge only.
- `busy` output 1: high while in SHIFT.
- `done` output 1: one-cycle pulse when `data_out` is updated.
- `data_out` output CRC_W: final remainder, held until the next completion.

## Operation
- N = ceil(MSG_W/J) beats per message. The last beat processes R = MSG_W − (N−1)·J bits, where 1 ≤ R ≤ J.
- Bit step, direct (non-augmented) form: fb = crc[CRC_W−1] ^ b; crc = (crc<<1) ^ (fb ? POLY : 0). One beat applies J steps combinationally (R steps on the last beat), consuming message bits MSB first.
- FSM states:
  - IDLE: on `start`, load crc←INIT, shift register←`data_in`, beat counter←0, then go to SHIFT.
  - SHIFT: each edge applies one beat, shifts the message register left by J and increments the counter. On the edge that applies beat N: `data_out`←result, `done`←1, return to IDLE.
- `start` while in SHIFT is ignored and does not stall, queue or restart the computation.
- `data_in` changes after acceptance have no effect.
- Result is independent of J for fixed CRC_W, POLY, INIT and MSG_W.
- Reset values: state IDLE, `busy`=0, `done`=0, `data_out`=0, internal registers 0.
- Reset asserted mid-computation aborts it. No `done` is produced, and `data_out` returns to 0 on the reset edge.

## Timing
- Start accepted at edge E. `busy`=1 during cycles E+1 through E+N.
- `done`=1 for exactly the one cycle following edge E+N, with `data_out` valid from that same cycle.
- Latency from the start edge to `data_out` valid is N+1 edges. Example: defaults give N=2, so done follows edge E+2.
- Back-to-back: `start` held high during the `done` cycle is accepted at edge E+N+1. Throughput is one message per N+1 cycles.
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package `crc_pkg` contains:
  - the state enum (IDLE, SHIFT);
  - a ceil-division constant function;
  - a counter-width function, clog2(N)+1.
- Sub-module `crc_step`: combinational, parametrised by CRC_W, POLY and J. Inputs are crc, J message bits and an active-bit count of 1..J. Output is the next crc. Bits beyond the count pass through unchanged.
- The top level holds only the FSM, counter, message shift register and output registers.

## Test plan
- Defaults (CRC_W=5, POLY=00101, INIT=0, MSG_W=6, J=3), `data_in`=6'b111111, start pulse: `data_out`=5'b11101, with `done` pulsed one cycle exactly 3 edges after the start edge.
- Defaults, `data_in`=6'b101011: `data_out`=5'b10011. `data_in`=6'b000000: `data_out`=5'b00000.
- J sweep 1 through 6 (J=4 and J=5 exercise the partial last beat), `data_in`=6'b111111: every configuration gives 5'b11101. Latency equals ceil(6/J)+1 edges.
- Start pulsed again during `busy` with a different `data_in`: ignored, and the original result 5'b11101 is delivered once. `start` held high continuously: one `done` every N+1 cycles.
- Reset asserted for one cycle during SHIFT: no `done`, `busy`=0 and `data_out`=0 next cycle. A subsequent start completes normally.
- Random MSG_W/CRC_W/POLY/INIT configurations against a bit-serial reference model, with J=1 and J=MSG_W compared for equality.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the unfolded CRC engine.
// Contents: FSM state encoding, a ceil-division helper and the beat-counter
// width helper. The helpers are constant functions used to size localparams.
package crc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Number of J-bit beats needed to cover a message of a bits.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter wide enough to hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/crc_step.sv
// One beat of the unfolded CRC LFSR: applies up to J message bits, MSB first.
// Ports: crc_i current remainder, bits_i beat bits (bits_i[J-1] is consumed
//        first), cnt_i number of active bits 1..J, crc_o next remainder.
module crc_step
  import crc_pkg::*;
#(
  parameter int          CRC_W = 5,
  parameter logic [31:0] POLY  = 32'h0000_0005,
  parameter int          J     = 3,
  localparam int         CNT_W = $clog2(J + 1)
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [J-1:0]     bits_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < J; i++) begin
      // Bits past the active count leave the remainder untouched, which is
      // how the shorter final beat of a message is handled.
      if (i < int'(cnt_i)) begin
        c = {c[CRC_W-2:0], 1'b0} ^
            ((c[CRC_W-1] ^ bits_i[J-1-i]) ? POLY[CRC_W-1:0] : '0);
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_unfold_engine.sv
// Multi-cycle CRC of a MSG_W-bit message, J bits per clock, direct form.
// Ports: clk, reset (sync, active high), start/data_in (sampled in IDLE),
//        busy (high while shifting), done (1-cycle pulse), data_out (held).
module crc_unfold_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W = 5,
  parameter logic [31:0] POLY  = 32'h0000_0005,
  parameter logic [31:0] INIT  = 32'h0000_0000,
  parameter int          MSG_W = 6,
  parameter int          J     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MSG_W-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] data_out
);

  localparam int N   = ceil_div(MSG_W, J);
  localparam int R   = MSG_W - (N - 1) * J;  // bits in the final beat
  localparam int CW  = cnt_width(N);
  localparam int SCW = $clog2(J + 1);

  state_e           state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [MSG_W-1:0] msg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [CRC_W-1:0] dout_q;

  logic             last_beat;
  logic [SCW-1:0]   step_cnt;

  assign last_beat = (cnt_q == CW'(N - 1));
  assign step_cnt  = last_beat ? SCW'(R) : SCW'(J);

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .J     (J)
  ) u_step (
    .crc_i  (crc_q),
    .bits_i (msg_q[MSG_W-1 -: J]),
    .cnt_i  (step_cnt),
    .crc_o  (crc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= '0;
      msg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            crc_q   <= INIT[CRC_W-1:0];
            msg_q   <= data_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at here.
          crc_q <= crc_d;
          msg_q <= msg_q << J;
          cnt_q <= cnt_q + CW'(1);
          if (last_beat) begin
            dout_q  <= crc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule
